// File: rtl/lbist_prpg.sv
// lbist_prpg: parametrised external-XOR LFSR pattern generator with a
// start/run/done session controller, a programmable pattern count and a
// valid/ready output handshake. Optional macro RPG_ALL_ZERO_EN turns the
// LFSR into a de Bruijn counter that also visits the all-zero state.
module lbist_prpg #(
  parameter int unsigned        BITS  = 4,
  parameter logic [BITS-1:0]    POLY  = 4'b0011,
  parameter logic [BITS-1:0]    SEED  = 4'b1000,
  parameter int unsigned        CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_load,
  input  logic [BITS-1:0]  seed_in,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] num_pat,
  output logic [BITS-1:0]  pattern,
  output logic             pat_valid,
  input  logic             pat_ready,
  output logic             busy,
  output logic             done,
  output logic             wrapped,
  output logic [CNT_W-1:0] pat_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [BITS-1:0]  r_lfsr;
  logic [BITS-1:0]  r_seed;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_target;
  logic             r_valid;
  logic             r_busy;
  logic             r_done;
  logic             r_wrapped;

  logic             w_fb;
  logic [BITS-1:0]  w_next;
  logic [BITS-1:0]  w_seed_sel;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_last;

  // Feedback, next LFSR state, runtime seed qualification and count compare
  always_comb begin
    w_fb = ^(POLY & r_lfsr);
`ifdef RPG_ALL_ZERO_EN
    w_fb       = w_fb ^ (r_lfsr[BITS-1:1] == '0);
    w_seed_sel = seed_in;
`else
    w_seed_sel = (seed_in == '0) ? SEED : seed_in;
`endif
    w_next    = {w_fb, r_lfsr[BITS-1:1]};
    w_cnt_inc = r_cnt + 1'b1;
    w_last    = (r_target != '0) && (w_cnt_inc == r_target);
  end

  // Session FSM with registered status outputs; LFSR advances only on accept
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_lfsr    <= SEED;
      r_seed    <= SEED;
      r_cnt     <= '0;
      r_target  <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_wrapped <= 1'b0;
    end else begin
      r_wrapped <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          // Load takes effect before a same-cycle start, so RUN begins at seed_in
          if (seed_load) begin
            r_lfsr <= w_seed_sel;
            r_seed <= w_seed_sel;
          end
          if (start) begin
            r_state  <= S_RUN;
            r_cnt    <= '0;
            r_target <= num_pat;
            r_valid  <= 1'b1;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
          end
        end
        S_RUN: begin
          if (pat_ready) begin
            r_cnt     <= w_cnt_inc;
            r_lfsr    <= w_next;
            r_wrapped <= (w_next == r_seed);
          end
          if (stop || (pat_ready && w_last)) begin
            r_state <= S_DONE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign pattern   = r_lfsr;
  assign pat_valid = r_valid;
  assign busy      = r_busy;
  assign done      = r_done;
  assign wrapped   = r_wrapped;
  assign pat_cnt   = r_cnt;

endmodule

// File: tb/tb_lbist_prpg.sv
// Scoreboard bench for lbist_prpg (default parameters). Expected patterns are
// queued when a session is started and popped on every accepted transfer.
module tb_lbist_prpg;

  logic        clk = 1'b0;
  logic        rst;
  logic        seed_load;
  logic [3:0]  seed_in;
  logic        start;
  logic        stop;
  logic [15:0] num_pat;
  logic [3:0]  pattern;
  logic        pat_valid;
  logic        pat_ready;
  logic        busy;
  logic        done;
  logic        wrapped;
  logic [15:0] pat_cnt;

  int n_chk  = 0;
  int n_pass = 0;
  logic [3:0] q_exp[$];

  lbist_prpg #(.BITS(4), .POLY(4'b0011), .SEED(4'b1000), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed_in(seed_in),
    .start(start), .stop(stop), .num_pat(num_pat), .pattern(pattern),
    .pat_valid(pat_valid), .pat_ready(pat_ready), .busy(busy), .done(done),
    .wrapped(wrapped), .pat_cnt(pat_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    else n_pass++;
  endtask

  // Independent reference: tap-by-tap XOR, shift right, new MSB = feedback
  function automatic logic [3:0] m_next(input logic [3:0] x);
    logic [3:0] poly;
    logic fb;
    poly = 4'b0011;
    fb = 1'b0;
    for (int i = 0; i < 4; i++) if (poly[i]) fb = fb ^ x[i];
`ifdef RPG_ALL_ZERO_EN
    if (x[3:1] == 3'b000) fb = ~fb;
`endif
    return {fb, x[3:1]};
  endfunction

  task automatic push_seq(input logic [3:0] s, input int n, output logic [3:0] fin);
    logic [3:0] x;
    x = s;
    for (int i = 0; i < n; i++) begin
      q_exp.push_back(x);
      x = m_next(x);
    end
    fin = x;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic begin_session(input logic ld, input logic [3:0] sd, input logic [15:0] n);
    seed_load = ld; seed_in = sd; num_pat = n; start = 1'b1;
    tick;
    start = 1'b0; seed_load = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    int k;
    k = 0;
    while (!done && k < max_cyc) begin
      tick;
      k++;
    end
    if (!done) chk("done_timeout", done, 1);
  endtask

  // Scoreboard consumer: every accepted transfer must match the queue head
  always @(negedge clk) begin
    if (pat_valid && pat_ready) begin
      if (q_exp.size() == 0) chk("sb_underflow", 64'(q_exp.size()), 64'd1);
      else chk("sb_pattern", pattern, q_exp.pop_front());
    end
  end

  initial begin
    logic [3:0] tbl [15];
    logic [3:0] fin;
    tbl = '{4'b1000, 4'b0100, 4'b0010, 4'b1001, 4'b1100, 4'b0110, 4'b1011, 4'b0101,
            4'b1010, 4'b1101, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001};
    rst = 1'b1; seed_load = 1'b0; seed_in = '0; start = 1'b0; stop = 1'b0;
    num_pat = '0; pat_ready = 1'b0;
    tick; tick;
    rst = 1'b0;
    chk("rst_pattern", pattern, 4'b1000);
    chk("rst_valid", pat_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wrapped", wrapped, 0);
    chk("rst_cnt", pat_cnt, 0);

    // Full 15-pattern session from the reset seed
    foreach (tbl[i]) q_exp.push_back(tbl[i]);
    fin = 4'b1000;
    for (int i = 0; i < 15; i++) fin = m_next(fin);
    pat_ready = 1'b1;
    begin_session(1'b0, 4'b0000, 16'd15);
    chk("seq_first_valid", pat_valid, 1);
    chk("seq_busy", busy, 1);
    wait_done(40);
    chk("seq_done", done, 1);
    chk("seq_cnt", pat_cnt, 15);
    chk("seq_wrapped", wrapped, (fin == 4'b1000) ? 1 : 0);
    chk("seq_final", pattern, fin);
    chk("seq_q_empty", 64'(q_exp.size()), 0);
    tick;
    chk("seq_wrap_pulse", wrapped, 0);
    chk("seq_done_held", done, 1);

    // Backpressure: ready 1,0,0,1
    pat_ready = 1'b0;
    push_seq(4'b1000, 2, fin);
    begin_session(1'b1, 4'b1000, 16'd2);
    pat_ready = 1'b1;
    tick;
    pat_ready = 1'b0;
    chk("bp_hold1", pattern, 4'b0100);
    chk("bp_valid1", pat_valid, 1);
    tick;
    chk("bp_hold2", pattern, 4'b0100);
    chk("bp_cnt_stall", pat_cnt, 1);
    pat_ready = 1'b1;
    tick;
    chk("bp_cnt", pat_cnt, 2);
    chk("bp_done", done, 1);
    chk("bp_final", pattern, 4'b0010);
    chk("bp_q_empty", 64'(q_exp.size()), 0);

    // Reseed from DONE with a simultaneous start
    push_seq(4'b0101, 15, fin);
    begin_session(1'b1, 4'b0101, 16'd15);
    chk("rs_first", pattern, 4'b0101);
    tick;
    chk("rs_second", pattern, 4'b1010);
    wait_done(40);
    chk("rs_cnt", pat_cnt, 15);
    chk("rs_wrapped", wrapped, (fin == 4'b0101) ? 1 : 0);
    chk("rs_q_empty", 64'(q_exp.size()), 0);

    // Free-run with stop on the 7th accept, then resume without reseeding
    push_seq(4'b1000, 7, fin);
    begin_session(1'b1, 4'b1000, 16'd0);
    repeat (6) tick;
    stop = 1'b1;
    tick;
    stop = 1'b0;
    chk("stop_done", done, 1);
    chk("stop_busy", busy, 0);
    chk("stop_cnt", pat_cnt, 7);
    chk("stop_frozen", pattern, fin);
    pat_ready = 1'b0;
    tick;
    chk("stop_hold", pattern, fin);
    push_seq(fin, 1, fin);
    begin_session(1'b0, 4'b0000, 16'd1);
    chk("resume_cnt0", pat_cnt, 0);
    chk("resume_done_clr", done, 0);
    pat_ready = 1'b1;
    wait_done(10);
    chk("resume_cnt", pat_cnt, 1);
    chk("resume_q_empty", 64'(q_exp.size()), 0);

    // Reset in the middle of a session
    push_seq(4'b1000, 5, fin);
    begin_session(1'b1, 4'b1000, 16'd0);
    repeat (5) tick;
    pat_ready = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("mrst_pattern", pattern, 4'b1000);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_valid", pat_valid, 0);
    chk("mrst_cnt", pat_cnt, 0);
    chk("mrst_q_empty", 64'(q_exp.size()), 0);

`ifdef RPG_ALL_ZERO_EN
    // Zero seed is legal; full 16-pattern period includes 0000
    seed_load = 1'b1; seed_in = 4'b0000;
    tick;
    seed_load = 1'b0;
    chk("zero_seed_kept", pattern, 4'b0000);
    push_seq(4'b1000, 16, fin);
    pat_ready = 1'b1;
    begin_session(1'b1, 4'b1000, 16'd16);
    wait_done(40);
    chk("db_cnt", pat_cnt, 16);
    chk("db_wrapped", wrapped, 1);
    chk("db_final", pattern, fin);
    chk("db_q_empty", 64'(q_exp.size()), 0);
`else
    // Zero seed is replaced by the reset seed
    seed_load = 1'b1; seed_in = 4'b0000;
    tick;
    seed_load = 1'b0;
    chk("zero_seed_sub", pattern, 4'b1000);
    push_seq(4'b1000, 2, fin);
    pat_ready = 1'b1;
    begin_session(1'b0, 4'b0000, 16'd2);
    wait_done(10);
    chk("zs_final", pattern, fin);
    chk("zs_q_empty", 64'(q_exp.size()), 0);
`endif

    pat_ready = 1'b0;
    tick;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
